// File: rtl/crc_pkg.sv
// crc_pkg: shared FSM state type and standard CRC polynomial constants
package crc_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  localparam logic [3:0]  CRC4_ITU    = 4'h3;
  localparam logic [7:0]  CRC8        = 8'h07;
  localparam logic [15:0] CRC16_CCITT = 16'h1021;
  localparam logic [31:0] CRC32       = 32'h04C11DB7;
endpackage

// File: rtl/crc_stream_engine_word_step.sv
// crc_word_step: folds one DATA_WIDTH-bit word MSB-first into a CRC (combinational)
//   crc_in  : CRC before the word
//   data    : word, bit DATA_WIDTH-1 processed first
//   crc_out : CRC after the word
module crc_word_step #(
  parameter int CRC_WIDTH = 4,
  parameter int DATA_WIDTH = 5,
  parameter logic [CRC_WIDTH-1:0] POLY = CRC_WIDTH'(4'h3)
) (
  input  logic [CRC_WIDTH-1:0]  crc_in,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [CRC_WIDTH-1:0]  crc_out
);
  always_comb begin
    crc_out = crc_in;
    for (int i = DATA_WIDTH - 1; i >= 0; i--)
      crc_out = {crc_out[CRC_WIDTH-2:0], 1'b0} ^ ((crc_out[CRC_WIDTH-1] ^ data[i]) ? POLY : '0);
  end
endmodule

// File: rtl/crc_stream_engine.sv
// crc_stream_engine: frame-oriented streaming CRC generator with valid/ready in and out
//   crc_initial : seed, sampled on the sop beat
//   din_*       : input word stream (vld/rdy/sop/eop) and data_in
//   data_out    : frame CRC ^ XOR_OUT, held with dout_vld until dout_rdy
//   crc_ok      : residue==0 flag, present only when CRC_CHECK_EN is defined
module crc_stream_engine import crc_pkg::*; #(
  parameter int CRC_WIDTH = 4,
  parameter int DATA_WIDTH = 5,
  parameter logic [CRC_WIDTH-1:0] POLY = CRC_WIDTH'(CRC4_ITU),
  parameter logic [CRC_WIDTH-1:0] XOR_OUT = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CRC_WIDTH-1:0]  crc_initial,
  input  logic                  din_vld,
  output logic                  din_rdy,
  input  logic                  din_sop,
  input  logic                  din_eop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [CRC_WIDTH-1:0]  data_out,
  output logic                  dout_vld,
  input  logic                  dout_rdy
`ifdef CRC_CHECK_EN
  ,
  output logic                  crc_ok
`endif
);
  state_t state, state_nxt;
  logic acc, upd, fin;
  logic [CRC_WIDTH-1:0] crc_q, crc_seed, crc_step;
  assign acc = din_vld & din_rdy;
  // non-sop beats in IDLE are accepted but do not touch the CRC
  assign upd = acc & (din_sop | state == ACCUM);
  assign fin = upd & din_eop;
  // an sop beat always restarts from the seed, also when it aborts a frame
  assign crc_seed = din_sop ? crc_initial : crc_q;
  crc_word_step #(.CRC_WIDTH(CRC_WIDTH), .DATA_WIDTH(DATA_WIDTH), .POLY(POLY)) u_step (
    .crc_in(crc_seed),
    .data(data_in),
    .crc_out(crc_step)
  );
  always_comb begin
    state_nxt = state;
    if (state == HOLD) state_nxt = dout_rdy ? IDLE : HOLD;
    else if (upd) state_nxt = din_eop ? HOLD : ACCUM;
  end
  // din_rdy and dout_vld are registered from the next state so neither
  // has a combinational path from dout_rdy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      crc_q    <= '0;
      data_out <= '0;
      dout_vld <= 1'b0;
      din_rdy  <= 1'b0;
    end else begin
      state    <= state_nxt;
      din_rdy  <= state_nxt != HOLD;
      dout_vld <= state_nxt == HOLD;
      if (upd) crc_q <= crc_step;
      if (fin) data_out <= crc_step ^ XOR_OUT;
    end
`ifdef CRC_CHECK_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) crc_ok <= 1'b0;
    else if (fin) crc_ok <= crc_step == '0;
    else if (state == HOLD && dout_rdy) crc_ok <= 1'b0;
`endif
endmodule

// File: tb/tb_crc_stream_engine.sv
// tb_crc_stream_engine: scoreboard bench for crc_stream_engine (CRC_CHECK_EN selects the CRC-8 check build)
module tb_crc_stream_engine;
`ifdef CRC_CHECK_EN
  localparam int CW = 8;
  localparam int DW = 8;
  localparam logic [CW-1:0] P = 8'h07;
`else
  localparam int CW = 4;
  localparam int DW = 5;
  localparam logic [CW-1:0] P = 4'h3;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CW-1:0] crc_initial = '0;
  logic din_vld = 1'b0, din_sop = 1'b0, din_eop = 1'b0, dout_rdy = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic din_rdy, dout_vld;
  logic [CW-1:0] data_out;
`ifdef CRC_CHECK_EN
  logic crc_ok;
`endif
  int checks = 0, failures = 0;
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] e;
  always #5 clk = ~clk;
  crc_stream_engine #(.CRC_WIDTH(CW), .DATA_WIDTH(DW), .POLY(P), .XOR_OUT('0)) dut (
    .clk(clk), .rst_n(rst_n), .crc_initial(crc_initial),
    .din_vld(din_vld), .din_rdy(din_rdy), .din_sop(din_sop), .din_eop(din_eop),
    .data_in(data_in), .data_out(data_out), .dout_vld(dout_vld), .dout_rdy(dout_rdy)
`ifdef CRC_CHECK_EN
    , .crc_ok(crc_ok)
`endif
  );
  function automatic logic [CW-1:0] model(input logic [CW-1:0] seed, input logic [DW-1:0] w [4], input int len);
    logic [CW-1:0] c = seed;
    for (int k = 0; k < len; k++)
      for (int i = DW - 1; i >= 0; i--)
        if (c[CW-1] ^ w[k][i]) c = (c << 1) ^ P;
        else c = c << 1;
    return c;
  endfunction
  task automatic drive(input logic [DW-1:0] d, input logic s, input logic eo);
    din_vld = 1'b1; data_in = d; din_sop = s; din_eop = eo;
  endtask
  task automatic idle();
    din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
  endtask
  task automatic handshake();
    dout_rdy = 1'b1;
    @(negedge clk);
    dout_rdy = 1'b0;
  endtask
  // drives one frame from a negedge, honouring din_rdy; returns at the negedge after eop is accepted
  task automatic send(input logic [CW-1:0] seed, input logic [DW-1:0] w [4], input int len, input logic [CW-1:0] expv);
    int n;
    exp_q.push_back(expv);
    for (int k = 0; k < len; k++) begin
      drive(w[k], k == 0, k == len - 1);
      crc_initial = (k == 0) ? seed : CW'($urandom);
      n = 0;
      while (!din_rdy && n < 100) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n >= 100) begin
        failures++;
        $display("FAIL send_ready: din_rdy=%0b after %0d cycles, required 1", din_rdy, n);
      end
      @(negedge clk);
    end
    idle();
  endtask
  task automatic test_reset();
    #3;
    checks += 3;
    if (data_out !== '0) begin failures++; $display("FAIL reset_data: got %h want 0", data_out); end
    if (dout_vld !== 1'b0) begin failures++; $display("FAIL reset_vld: got %b want 0", dout_vld); end
    if (din_rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy: got %b want 0", din_rdy); end
`ifdef CRC_CHECK_EN
    checks++;
    if (crc_ok !== 1'b0) begin failures++; $display("FAIL reset_ok: got %b want 0", crc_ok); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (din_rdy !== 1'b1) begin failures++; $display("FAIL post_reset_rdy: got %b want 1", din_rdy); end
  endtask
`ifndef CRC_CHECK_EN
  task automatic test_single();
    crc_initial = '0;
    drive(5'b00100, 1'b1, 1'b1);
    exp_q.push_back(4'hC);
    @(negedge clk);
    idle();
    e = exp_q.pop_front();
    checks += 2;
    if (dout_vld !== 1'b1) begin failures++; $display("FAIL single_latency: dout_vld=%b want 1", dout_vld); end
    if (data_out !== e) begin failures++; $display("FAIL single_data: got %h want %h", data_out, e); end
    handshake();
    checks += 2;
    if (dout_vld !== 1'b0) begin failures++; $display("FAIL single_release: dout_vld=%b want 0", dout_vld); end
    if (din_rdy !== 1'b1) begin failures++; $display("FAIL single_idle_rdy: got %b want 1", din_rdy); end
  endtask
  task automatic test_two_beat();
    crc_initial = '0;
    drive(5'b00001, 1'b1, 1'b0);
    exp_q.push_back(4'hA);
    checks++;
    if (din_rdy !== 1'b1) begin failures++; $display("FAIL two_rdy0: got %b want 1", din_rdy); end
    @(negedge clk);
    drive(5'b00000, 1'b0, 1'b1);
    crc_initial = 4'hF;
    checks += 2;
    if (din_rdy !== 1'b1) begin failures++; $display("FAIL two_rdy1: got %b want 1", din_rdy); end
    if (dout_vld !== 1'b0) begin failures++; $display("FAIL two_early_vld: got %b want 0", dout_vld); end
    @(negedge clk);
    idle();
    e = exp_q.pop_front();
    checks += 3;
    if (dout_vld !== 1'b1) begin failures++; $display("FAIL two_vld: got %b want 1", dout_vld); end
    if (data_out !== e) begin failures++; $display("FAIL two_data: got %h want %h", data_out, e); end
    if (din_rdy !== 1'b0) begin failures++; $display("FAIL two_hold_rdy: got %b want 0", din_rdy); end
    handshake();
  endtask
  task automatic test_stall();
    crc_initial = '0;
    drive(5'b00100, 1'b1, 1'b1);
    exp_q.push_back(4'hC);
    @(negedge clk);
    drive(5'b00001, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checks += 3;
      if (dout_vld !== 1'b1) begin failures++; $display("FAIL stall_vld[%0d]: got %b want 1", i, dout_vld); end
      if (data_out !== exp_q[0]) begin failures++; $display("FAIL stall_data[%0d]: got %h want %h", i, data_out, exp_q[0]); end
      if (din_rdy !== 1'b0) begin failures++; $display("FAIL stall_rdy[%0d]: got %b want 0", i, din_rdy); end
      @(negedge clk);
    end
    e = exp_q.pop_front();
    checks++;
    if (data_out !== e) begin failures++; $display("FAIL stall_final: got %h want %h", data_out, e); end
    handshake();
    exp_q.push_back(4'h3);
    checks += 2;
    if (dout_vld !== 1'b0) begin failures++; $display("FAIL stall_exit_vld: got %b want 0", dout_vld); end
    if (din_rdy !== 1'b1) begin failures++; $display("FAIL stall_exit_rdy: got %b want 1", din_rdy); end
    @(negedge clk);
    idle();
    e = exp_q.pop_front();
    checks += 2;
    if (dout_vld !== 1'b1) begin failures++; $display("FAIL stall_next_vld: got %b want 1", dout_vld); end
    if (data_out !== e) begin failures++; $display("FAIL stall_next_data: got %h want %h", data_out, e); end
    handshake();
  endtask
  task automatic test_abort();
    drive(5'b11111, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (dout_vld !== 1'b0) begin failures++; $display("FAIL discard_vld: got %b want 0", dout_vld); end
    crc_initial = 4'h5;
    drive(5'b00001, 1'b1, 1'b0);
    @(negedge clk);
    crc_initial = '0;
    drive(5'b00100, 1'b1, 1'b1);
    exp_q.push_back(4'hC);
    checks++;
    if (dout_vld !== 1'b0) begin failures++; $display("FAIL abort_early_vld: got %b want 0", dout_vld); end
    @(negedge clk);
    idle();
    e = exp_q.pop_front();
    checks += 2;
    if (dout_vld !== 1'b1) begin failures++; $display("FAIL abort_vld: got %b want 1", dout_vld); end
    if (data_out !== e) begin failures++; $display("FAIL abort_data: got %h want %h", data_out, e); end
    handshake();
    checks++;
    if (dout_vld !== 1'b0) begin failures++; $display("FAIL abort_extra: got %b want 0", dout_vld); end
  endtask
`else
  task automatic test_check();
    logic [CW-1:0] wants [3] = '{8'h07, 8'h00, 8'h07};
    logic oks [3] = '{1'b0, 1'b1, 1'b0};
    logic [DW-1:0] w [3][4] = '{'{8'h01, 8'h00, 8'h00, 8'h00}, '{8'h01, 8'h07, 8'h00, 8'h00}, '{8'h01, 8'h06, 8'h00, 8'h00}};
    int lens [3] = '{1, 2, 2};
    for (int t = 0; t < 3; t++) begin
      send('0, w[t], lens[t], wants[t]);
      e = exp_q.pop_front();
      checks += 3;
      if (dout_vld !== 1'b1) begin failures++; $display("FAIL check_vld[%0d]: got %b want 1", t, dout_vld); end
      if (data_out !== e) begin failures++; $display("FAIL check_data[%0d]: got %h want %h", t, data_out, e); end
      if (crc_ok !== oks[t]) begin failures++; $display("FAIL check_ok[%0d]: got %b want %b", t, crc_ok, oks[t]); end
      handshake();
    end
  endtask
`endif
  task automatic test_reset_mid();
    logic [DW-1:0] w [4] = '{'1, '0, '0, '0};
    logic [DW-1:0] v [4] = '{DW'(4), '0, '0, '0};
    send('0, w, 1, model('0, w, 1));
    checks++;
    if (dout_vld !== 1'b1) begin failures++; $display("FAIL rmid_pre_vld: got %b want 1", dout_vld); end
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks += 3;
    if (data_out !== '0) begin failures++; $display("FAIL rmid_data: got %h want 0", data_out); end
    if (dout_vld !== 1'b0) begin failures++; $display("FAIL rmid_vld: got %b want 0", dout_vld); end
    if (din_rdy !== 1'b0) begin failures++; $display("FAIL rmid_rdy: got %b want 0", din_rdy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    crc_initial = CW'(5);
    drive(DW'(1), 1'b1, 1'b0);
    @(negedge clk);
    idle();
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`ifdef CRC_CHECK_EN
    send('0, v, 1, model('0, v, 1));
`else
    send('0, v, 1, 4'hC);
`endif
    e = exp_q.pop_front();
    checks += 2;
    if (dout_vld !== 1'b1) begin failures++; $display("FAIL rmid_after_vld: got %b want 1", dout_vld); end
    if (data_out !== e) begin failures++; $display("FAIL rmid_after_data: got %h want %h", data_out, e); end
    handshake();
  endtask
  task automatic test_back_to_back();
    dout_rdy = 1'b1;
    fork
      for (int f = 0; f < 8; f++) begin
        logic [DW-1:0] w [4];
        logic [CW-1:0] s;
        int len;
        len = $urandom_range(1, 4);
        s = CW'($urandom);
        for (int k = 0; k < 4; k++) w[k] = DW'($urandom);
        send(s, w, len, model(s, w, len));
      end
      for (int f = 0; f < 8; f++) begin
        int n = 0;
        while (!dout_vld && n < 200) begin
          @(negedge clk);
          n++;
        end
        checks++;
        if (n >= 200) begin
          failures++;
          $display("FAIL b2b_timeout[%0d]: dout_vld=%b after %0d cycles, required 1", f, dout_vld, n);
        end else if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL b2b_unexpected[%0d]: got %h, required no output", f, data_out);
        end else begin
          e = exp_q.pop_front();
          if (data_out !== e) begin failures++; $display("FAIL b2b_data[%0d]: got %h want %h", f, data_out, e); end
        end
        @(negedge clk);
      end
    join
    dout_rdy = 1'b0;
  endtask
  initial begin
    test_reset();
`ifndef CRC_CHECK_EN
    test_single();
    test_two_beat();
    test_stall();
    test_abort();
`else
    test_check();
`endif
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/crc_stream_engine.md
# crc_stream_engine

Parametrised, frame-oriented streaming CRC generator. Accepts one DATA_WIDTH-bit word per beat under a valid/ready handshake and folds it MSB-first into a CRC_WIDTH-bit register seeded from crc_initial at start-of-frame. It emits one registered CRC per frame through a valid/ready output buffer. It supersedes the fixed single-word parallel CRC-4 block and sits between framers and line encoders on the datapath.

## Interface
- CRC_WIDTH, 4: CRC register width (2..32).
- DATA_WIDTH, 5: input word width (1..64).
- POLY, 4'h3: generator polynomial without the implicit x^CRC_WIDTH term; default is x^4+x+1.
- XOR_OUT, 0: value XORed into the result before output.
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- crc_initial  input  CRC_WIDTH  seed, sampled on the sop beat.
- din_vld  input  1  input word valid.
- din_rdy  output  1  engine can accept a word.
- din_sop  input  1  first word of the frame.
- din_eop  input  1  last word of the frame.
- data_in  input  DATA_WIDTH  word; bit DATA_WIDTH-1 is processed first.
- data_out  output  CRC_WIDTH  frame CRC (after XOR_OUT).
- dout_vld  output  1  data_out valid.
- dout_rdy  input  1  downstream accepts data_out.
- crc_ok  output  1  residue check result; exists only with CRC_CHECK_EN.

## Operation
- A beat is accepted when din_vld and din_rdy are both high.
- FSM states:
  - IDLE: din_rdy=1. An accepted sop beat goes to ACCUM, or to HOLD if eop is also set. A non-sop beat is accepted and discarded.
  - ACCUM: din_rdy=1. Each accepted beat updates the CRC. An eop beat goes to HOLD. An sop beat aborts the current frame, reseeds from crc_initial, processes the word, and stays in ACCUM (or goes to HOLD if eop is also set).
  - HOLD: din_rdy=0 and dout_vld=1. data_out and crc_ok are frozen. dout_rdy=1 returns to IDLE.
- Per-word update: DATA_WIDTH serial steps unrolled combinationally. Each step computes fb = crc[MSB] ^ d, then crc = (crc<<1) ^ (fb ? POLY : 0).
- The seed for the sop word is crc_initial, not the stale register value.
- data_out = crc_final ^ XOR_OUT.
- Reset values: state=IDLE, crc register=0, data_out=0, dout_vld=0, crc_ok=0. din_rdy=1 once reset deasserts.
- Reset mid-frame discards the partial CRC. No output is produced for the aborted frame.

## Timing
- Throughput: one word per clock while in IDLE or ACCUM.
- Latency: dout_vld rises on the clock edge that accepts the eop beat, so it is visible the cycle after that beat is presented.
- Single output buffer. The beat after eop stalls, with din_rdy low, until the output handshake completes. Minimum gap between frames is one cycle with dout_rdy held high.
- din_rdy is a registered function of state only, with no combinational path from dout_rdy.
- dout_vld, once raised, stays high until dout_rdy is sampled high.

## Configuration
- CRC_CHECK_EN defined:
  - adds the crc_ok output.
  - In HOLD, crc_ok=1 iff the final CRC register, before XOR_OUT, equals 0. This is the residue check for a frame whose last words carry the transmitted CRC.
  - crc_ok updates together with dout_vld.
- CRC_CHECK_EN undefined:
  - the port and its comparator are absent.
  - All other behaviour is identical.

## Structure
- Package crc_pkg holds:
  - the FSM state enum (IDLE, ACCUM, HOLD).
  - standard polynomial constants (CRC4_ITU=4'h3, CRC8=8'h07, CRC16_CCITT=16'h1021, CRC32=32'h04C11DB7).
- Sub-module crc_word_step (combinational): inputs crc_in and data; output crc_out. Parametrised by CRC_WIDTH, DATA_WIDTH and POLY, and instantiated once.

## Test plan
- Defaults, crc_initial=0, one beat data_in=5'b00100 with sop=eop=1 -> next cycle dout_vld=1, data_out=4'hC.
- Defaults, two-beat frame 5'b00001 (sop) then 5'b00000 (eop) -> data_out=4'hA. din_rdy stays high through both beats.
- Hold dout_rdy=0 for 5 cycles after eop -> dout_vld and data_out stable, din_rdy=0 throughout. On dout_rdy=1, IDLE is reached the next cycle.
- sop arriving mid-frame (abort), then single word 5'b00100 with eop -> data_out=4'hC. The first frame produces no output.
- Assert rst_n=0 mid-frame -> all outputs 0 asynchronously. The following frame 5'b00100 yields 4'hC.
- CRC_CHECK_EN with CRC_WIDTH=8, DATA_WIDTH=8, POLY=8'h07:
  - frame 8'h01 -> data_out=8'h07.
  - frame 8'h01, 8'h07 -> data_out=8'h00, crc_ok=1.
  - frame 8'h01, 8'h06 -> crc_ok=0.
